// File: rtl/mpu9250_sampler.sv
// Periodic burst reader for an MPU9250 behind a byte-level I2C master: wakes the device once,
// then fetches the 14-byte accel/temp/gyro block every sample period and publishes it atomically.
module mpu9250_sampler #(
    parameter int         SYSTEM_CLOCK = 100_000_000,
    parameter int         SAMPLE_RATE  = 1_000,
    parameter logic [6:0] DEV_ADDR     = 7'h68,
    parameter int         WDOG_CYCLES  = 65_535
) (
    input  logic               clk,
    input  logic               rst,
    output logic               en,
    output logic [6:0]         addr,
    output logic               write,
    output logic [7:0]         wdata,
    output logic               multibyte_n,
    input  logic [7:0]         rdata,
    input  logic               act,
    input  logic               next,
    input  logic               err,
    output logic signed [15:0] accel_x,
    output logic signed [15:0] accel_y,
    output logic signed [15:0] accel_z,
    output logic signed [15:0] temp,
    output logic signed [15:0] gyro_x,
    output logic signed [15:0] gyro_y,
    output logic signed [15:0] gyro_z,
    output logic               sample_valid,
    output logic               busy,
    output logic [7:0]         err_count
);
    localparam int PERIOD = SYSTEM_CLOCK / SAMPLE_RATE;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int WW     = (WDOG_CYCLES > 0) ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam logic [CW-1:0] RELOAD   = CW'(PERIOD - 1);
    localparam logic [WW-1:0] WDOG_LIM = WW'(WDOG_CYCLES);

    localparam logic [3:0] INIT_REG   = 4'd0;
    localparam logic [3:0] INIT_DATA  = 4'd1;
    localparam logic [3:0] INIT_STOP  = 4'd2;
    localparam logic [3:0] WAIT       = 4'd3;
    localparam logic [3:0] RD_REG     = 4'd4;
    localparam logic [3:0] RD_RESTART = 4'd5;
    localparam logic [3:0] RD_DATA    = 4'd6;
    localparam logic [3:0] RD_STOP    = 4'd7;
    localparam logic [3:0] ABORT      = 4'd8;

    logic [3:0]       state_q, state_d;
    logic             en_q, en_d, write_q, write_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             next_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             init_done_q, init_done_d;
    logic             pend_q, pend_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic [7:0]       rx_q [14];
    logic [6:0][15:0] word_q, word_d;
    logic             sv_q, sv_d, busy_q, busy_d, from_init_q, from_init_d;
    logic [7:0]       errc_q, errc_d;
    logic             byte_done, expire, go, abort, capture;

    assign byte_done = next && !next_q;
    assign expire    = init_done_q && (cnt_q == '0);
    assign go        = (state_q == WAIT) && (expire || pend_q) && !act;
    assign abort     = (state_q != WAIT) && (state_q != ABORT) && (err || wdog_q == WDOG_LIM);
    assign capture   = (state_q == RD_DATA) && byte_done && !abort;

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        pend_d      = pend_q;
        bcnt_d      = bcnt_q;
        word_d      = word_q;
        sv_d        = 1'b0;
        busy_d      = busy_q;
        from_init_d = from_init_q;
        errc_d      = errc_q;

        // Free-running period grid once init is done; a missed tick is remembered once.
        if (init_done_q) cnt_d = expire ? RELOAD : cnt_q - CW'(1);
        if (go) pend_d = 1'b0;
        else if (expire) pend_d = 1'b1;

        if (abort) begin
            state_d     = ABORT;
            en_d        = 1'b0;
            bcnt_d      = 4'd0;
            errc_d      = (errc_q == 8'hFF) ? errc_q : errc_q + 8'd1;
            from_init_d = (state_q == INIT_REG) || (state_q == INIT_DATA) ||
                          (state_q == INIT_STOP);
        end else begin
            case (state_q)
                INIT_REG: begin
                    if (!en_q) begin
                        en_d    = 1'b1;
                        write_d = 1'b1;
                        wdata_d = 8'h6B;
                        busy_d  = 1'b1;
                    end else if (byte_done) begin
                        wdata_d = 8'h01;
                        state_d = INIT_DATA;
                    end
                end
                INIT_DATA: begin
                    if (byte_done) begin
                        en_d    = 1'b0;
                        state_d = INIT_STOP;
                    end
                end
                INIT_STOP: begin
                    if (!act) begin
                        cnt_d       = RELOAD;
                        init_done_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = WAIT;
                    end
                end
                WAIT: begin
                    if (go) begin
                        en_d    = 1'b1;
                        write_d = 1'b1;
                        wdata_d = 8'h3B;
                        busy_d  = 1'b1;
                        state_d = RD_REG;
                    end
                end
                RD_REG: begin
                    if (byte_done) begin
                        write_d = 1'b0;
                        state_d = RD_RESTART;
                    end
                end
                RD_RESTART: begin
                    bcnt_d  = 4'd0;
                    state_d = RD_DATA;
                end
                RD_DATA: begin
                    // Dropping en after byte 12 makes byte 13 the NACKed last byte.
                    if (byte_done) begin
                        bcnt_d = bcnt_q + 4'd1;
                        if (bcnt_q == 4'd12) en_d = 1'b0;
                        if (bcnt_q == 4'd13) state_d = RD_STOP;
                    end
                end
                RD_STOP: begin
                    if (!act) begin
                        for (int i = 0; i < 7; i++) word_d[i] = {rx_q[2*i], rx_q[2*i+1]};
                        sv_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = WAIT;
                    end
                end
                ABORT: begin
                    if (!act) begin
                        busy_d  = 1'b0;
                        state_d = from_init_q ? INIT_REG : WAIT;
                    end
                end
                default: state_d = INIT_REG;
            endcase
        end

        if (byte_done || (state_d != state_q) || (state_q == WAIT) || (state_q == ABORT))
            wdog_d = '0;
        else
            wdog_d = wdog_q + WW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT_REG;
            en_q        <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= 8'h00;
            next_q      <= 1'b0;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            pend_q      <= 1'b0;
            wdog_q      <= '0;
            bcnt_q      <= 4'd0;
            rx_q        <= '{default: '0};
            word_q      <= '0;
            sv_q        <= 1'b0;
            busy_q      <= 1'b0;
            from_init_q <= 1'b0;
            errc_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            next_q      <= next;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            pend_q      <= pend_d;
            wdog_q      <= wdog_d;
            bcnt_q      <= bcnt_d;
            word_q      <= word_d;
            sv_q        <= sv_d;
            busy_q      <= busy_d;
            from_init_q <= from_init_d;
            errc_q      <= errc_d;
            if (capture) rx_q[bcnt_q] <= rdata;
        end
    end

    assign en           = en_q;
    assign addr         = DEV_ADDR;
    assign write        = write_q;
    assign wdata        = wdata_q;
    assign multibyte_n  = 1'b0;
    assign accel_x      = word_q[0];
    assign accel_y      = word_q[1];
    assign accel_z      = word_q[2];
    assign temp         = word_q[3];
    assign gyro_x       = word_q[4];
    assign gyro_y       = word_q[5];
    assign gyro_z       = word_q[6];
    assign sample_valid = sv_q;
    assign busy         = busy_q;
    assign err_count    = errc_q;
endmodule

// File: tb/tb_mpu9250_sampler.sv
// Bench for mpu9250_sampler: behavioural I2C master/slave drives the bus; tasks check each scenario.
module tb_mpu9250_sampler;
    localparam int SYS = 200_000;
    localparam int SR  = 1_000;
    localparam int P   = SYS / SR;
    localparam int WD  = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en, write, multibyte_n, sample_valid, busy;
    logic [6:0]  addr;
    logic [7:0]  wdata, err_count;
    logic [7:0]  rdata = 8'h00;
    logic        act = 1'b0, next = 1'b0, err = 1'b0;
    logic [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;

    int n_tests = 0, n_fail = 0, exp_err = 0, sv_cnt = 0;
    logic [7:0] mem [14];
    logic [7:0] wq [$];
    int mst_err_at = -1, mst_err_left = 0, mst_ridx = 0;
    bit mst_stall = 1'b0;

    mpu9250_sampler #(.SYSTEM_CLOCK(SYS), .SAMPLE_RATE(SR), .DEV_ADDR(7'h68), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .rst(rst), .en(en), .addr(addr), .write(write), .wdata(wdata),
        .multibyte_n(multibyte_n), .rdata(rdata), .act(act), .next(next), .err(err),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp(temp),
        .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .sample_valid(sample_valid), .busy(busy), .err_count(err_count));

    always #5 clk = ~clk;
    always @(posedge clk) if (sample_valid) sv_cnt <= sv_cnt + 1;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Expected sample word i: big-endian pair from the slave register image.
    function automatic logic [15:0] exp_word(int i);
        return {mem[2*i], mem[2*i+1]};
    endfunction

    // Master + slave model: one transaction per en assertion.
    task automatic run_tx();
        int bidx, d, err_at;
        bit stall, last, wr;
        err_at = -1;
        if (mst_err_left > 0) begin err_at = mst_err_at; mst_err_left--; end
        stall = mst_stall; mst_stall = 1'b0;
        bidx = 0; last = 1'b0; mst_ridx = 0;
        act = 1'b1;
        if (stall) begin
            for (int i = 0; i < 5000 && en && !rst; i++) tick();
            repeat (2) tick();
            act = 1'b0;
            return;
        end
        forever begin
            d = $urandom_range(1, 3);
            for (int i = 0; i < d; i++) begin
                tick();
                if (rst) begin act = 1'b0; return; end
            end
            wr = write;
            if (bidx == err_at) begin
                err = 1'b1; tick(); err = 1'b0;
                for (int i = 0; i < 50 && en && !rst; i++) tick();
                repeat (2) tick();
                act = 1'b0;
                return;
            end
            if (wr) wq.push_back(wdata);
            else rdata = mem[mst_ridx];
            next = 1'b1; tick(); next = 1'b0;
            bidx++;
            if (!wr) mst_ridx++;
            if (rst) begin act = 1'b0; return; end
            if (last) break;
            if (!en) begin
                if (wr) break;
                last = 1'b1;
            end
        end
        repeat (2) tick();
        act = 1'b0;
    endtask

    initial begin
        forever begin
            tick();
            if (en && !act && !rst) run_tx();
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (en !== 1'b0 || write !== 1'b0 || wdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_cmd en=%b write=%b wdata=%h, required 0 0 00", en, write, wdata);
        end
        n_tests++;
        if (busy !== 1'b0 || sample_valid !== 1'b0 || err_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_status busy=%b sv=%b errc=%0d, required 0 0 0", busy, sample_valid, err_count);
        end
        n_tests++;
        if ({accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z} !== 112'd0) begin
            n_fail++; $display("FAIL reset_words accel_x=%h gyro_z=%h, required all zero", accel_x, gyro_z);
        end
        n_tests++;
        if (addr !== 7'h68 || multibyte_n !== 1'b0) begin
            n_fail++; $display("FAIL const_outs addr=%h mb_n=%b, required 68 0", addr, multibyte_n);
        end
        exp_err = 0;
        wq.delete();
        rst = 1'b0;
        n_tests++;
        if (en !== 1'b0) begin n_fail++; $display("FAIL init_first_cycle en=%b, required 0", en); end
        tick();
        n_tests++;
        if (en !== 1'b1 || write !== 1'b1 || wdata !== 8'h6B) begin
            n_fail++; $display("FAIL init_start en=%b write=%b wdata=%h, required 1 1 6b", en, write, wdata);
        end
    endtask

    task automatic test_init();
        int n;
        for (int k = 0; k < 500 && busy; k++) tick();
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL init_busy_fall busy=%b, required 0", busy); end
        n_tests++;
        if (wq.size() != 2 || wq[0] !== 8'h6B || wq[1] !== 8'h01) begin
            n_fail++; $display("FAIL init_frame bytes=%0d first=%h, required 2 bytes 6b 01", wq.size(), wq.size() > 0 ? wq[0] : 8'h00);
        end
        n = 0;
        while (!en && n < 3 * P) begin tick(); n++; end
        n_tests++;
        if (n != P) begin n_fail++; $display("FAIL first_read_delay got %0d cycles, required %0d", n, P); end
        n_tests++;
        if (en !== 1'b1 || write !== 1'b1 || wdata !== 8'h3B) begin
            n_fail++; $display("FAIL rd_reg_cmd en=%b write=%b wdata=%h, required 1 1 3b", en, write, wdata);
        end
    endtask

    task automatic test_read();
        logic [15:0] got [7];
        for (int k = 0; k < 2 * P && !sample_valid; k++) tick();
        n_tests++;
        if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL read_sv_timeout sv=%b, required 1", sample_valid); end
        got = '{accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z};
        n_tests++;
        if (got[0] !== 16'h0102 || got[6] !== 16'h0D0E) begin
            n_fail++; $display("FAIL read_fixed accel_x=%h gyro_z=%h, required 0102 0d0e", got[0], got[6]);
        end
        for (int i = 1; i < 6; i++) begin
            n_tests++;
            if (got[i] !== exp_word(i)) begin n_fail++; $display("FAIL read_word%0d got %h, required %h", i, got[i], exp_word(i)); end
        end
        n_tests++;
        if (busy !== 1'b0 || act !== 1'b0) begin n_fail++; $display("FAIL read_idle busy=%b act=%b, required 0 0", busy, act); end
        tick();
        n_tests++;
        if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL read_sv_pulse sv=%b, required 0", sample_valid); end
    endtask

    task automatic test_random_reads();
        logic [15:0] got [7];
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 14; i++) mem[i] = 8'($urandom);
            for (int k = 0; k < 2 * P && !sample_valid; k++) tick();
            n_tests++;
            if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL rand%0d_sv_timeout sv=%b, required 1", r, sample_valid); end
            got = '{accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z};
            for (int i = 0; i < 7; i++) begin
                n_tests++;
                if (got[i] !== exp_word(i)) begin n_fail++; $display("FAIL rand%0d_word%0d got %h, required %h", r, i, got[i], exp_word(i)); end
            end
            tick();
        end
    endtask

    task automatic test_read_nack();
        logic [15:0] held;
        int m, sv0;
        bit seen_low;
        held = accel_x; sv0 = sv_cnt;
        mst_err_at = 0; mst_err_left = 1;
        exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        for (int k = 0; k < 2 * P && !en; k++) tick();
        m = 0; seen_low = 1'b0;
        while (m < 3 * P) begin
            tick(); m++;
            if (!en) seen_low = 1'b1;
            if (en && seen_low) break;
        end
        n_tests++;
        if (m != P) begin n_fail++; $display("FAIL nack_next_read got %0d cycles, required %0d", m, P); end
        n_tests++;
        if (err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL nack_errc got %0d, required %0d", err_count, exp_err); end
        n_tests++;
        if (sv_cnt != sv0 || accel_x !== held) begin
            n_fail++; $display("FAIL nack_hold sv pulses %0d accel_x=%h, required 0 pulses %h", sv_cnt - sv0, accel_x, held);
        end
        for (int k = 0; k < 2 * P && !sample_valid; k++) tick();
        n_tests++;
        if (sample_valid !== 1'b1 || gyro_z !== exp_word(6)) begin
            n_fail++; $display("FAIL nack_recover sv=%b gyro_z=%h, required 1 %h", sample_valid, gyro_z, exp_word(6));
        end
        tick();
    endtask

    task automatic test_wdog();
        int k, sv0;
        sv0 = sv_cnt;
        mst_stall = 1'b1;
        exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        for (int j = 0; j < 2 * P && !en; j++) tick();
        k = 0;
        while (en && k < 4 * WD) begin tick(); k++; end
        n_tests++;
        if (k < WD || k > WD + 2) begin n_fail++; $display("FAIL wdog_abort en high %0d cycles, required %0d..%0d", k, WD, WD + 2); end
        for (int j = 0; j < 50 && busy; j++) tick();
        n_tests++;
        if (err_count !== 8'(exp_err) || en !== 1'b0) begin
            n_fail++; $display("FAIL wdog_errc errc=%0d en=%b, required %0d 0", err_count, en, exp_err);
        end
        n_tests++;
        if (sv_cnt != sv0) begin n_fail++; $display("FAIL wdog_no_sample pulses %0d, required 0", sv_cnt - sv0); end
    endtask

    task automatic test_init_nack();
        rst = 1'b1;
        repeat (2) tick();
        wq.delete();
        mst_err_at = 1; mst_err_left = 1;
        exp_err = 1;
        rst = 1'b0;
        for (int k = 0; k < 500 && wq.size() < 3; k++) tick();
        n_tests++;
        if (wq.size() < 3 || wq[0] !== 8'h6B || wq[1] !== 8'h6B || wq[2] !== 8'h01) begin
            n_fail++; $display("FAIL init_retry bytes=%0d, required 6b 6b 01", wq.size());
        end
        n_tests++;
        if (err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL init_nack_errc got %0d, required %0d", err_count, exp_err); end
    endtask

    task automatic test_err_saturate();
        rst = 1'b1;
        repeat (2) tick();
        wq.delete();
        mst_err_at = 0; mst_err_left = 300;
        exp_err = 255;
        rst = 1'b0;
        for (int k = 0; k < 20000 && (mst_err_left > 0 || wq.size() < 2); k++) tick();
        n_tests++;
        if (err_count !== 8'(exp_err)) begin n_fail++; $display("FAIL err_saturate got %0d, required %0d", err_count, exp_err); end
        n_tests++;
        if (wq.size() != 2 || wq[0] !== 8'h6B) begin n_fail++; $display("FAIL sat_then_init bytes=%0d, required 6b 01", wq.size()); end
    endtask

    task automatic test_reset_midread();
        for (int k = 0; k < 3 * P && !sample_valid; k++) tick();
        tick();
        for (int k = 0; k < 3 * P && !(act && mst_ridx == 7); k++) tick();
        n_tests++;
        if (mst_ridx != 7) begin n_fail++; $display("FAIL midread_reach idx=%0d, required 7", mst_ridx); end
        rst = 1'b1;
        tick();
        n_tests++;
        if (en !== 1'b0 || write !== 1'b0 || wdata !== 8'h00 || busy !== 1'b0 || sample_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_cmd en=%b write=%b wdata=%h busy=%b sv=%b, required 0 0 00 0 0", en, write, wdata, busy, sample_valid);
        end
        n_tests++;
        if (err_count !== 8'd0 || {accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z} !== 112'd0) begin
            n_fail++; $display("FAIL midrst_regs errc=%0d accel_x=%h, required 0 0000", err_count, accel_x);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10 && !en; k++) tick();
        n_tests++;
        if (en !== 1'b1 || write !== 1'b1 || wdata !== 8'h6B) begin
            n_fail++; $display("FAIL midrst_reinit en=%b write=%b wdata=%h, required 1 1 6b", en, write, wdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 14; i++) mem[i] = 8'(i + 1);
        test_reset();
        test_init();
        test_read();
        test_random_reads();
        test_read_nack();
        test_wdog();
        test_init_nack();
        test_err_saturate();
        test_reset_midread();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mpu9250_sampler.md
MPU9250_SAMPLER -- requirements
Module: mpu9250_sampler

Interface
REQ-001 SHALL have parameter SYSTEM_CLOCK, default 100_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_RATE, default 1_000, meaning samples per second.
REQ-003 SHALL have parameter DEV_ADDR, default 7'h68, meaning the MPU9250 7-bit slave address.
REQ-004 SHALL have parameter WDOG_CYCLES, default 65_535, meaning the maximum number of clk cycles allowed between byte completions.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all logic SHALL be on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have ports en, addr[6:0], write, wdata[7:0] and multibyte_n, all outputs, which drive the I2C master command inputs.
REQ-008 SHALL have ports rdata[7:0], act, next and err, all inputs, which come from the I2C master.
REQ-009 SHALL have outputs accel_x, accel_y, accel_z, temp, gyro_x, gyro_y and gyro_z, each 16 bits: signed registered sample words.
REQ-010 SHALL have output sample_valid, 1 bit: a single-cycle pulse when all 7 words update together.
REQ-011 SHALL have output busy, 1 bit: high from en assertion until act is seen low after the transaction.
REQ-012 SHALL have output err_count, 8 bits: a saturating count of aborted transactions.

Function
REQ-013 SHALL implement FSM states INIT_REG, INIT_DATA, INIT_STOP, WAIT, RD_REG, RD_RESTART, RD_DATA, RD_STOP and ABORT.
REQ-014 SHALL drive addr = DEV_ADDR and multibyte_n = 0 at all times.
REQ-015 SHALL hold en, write and wdata stable from assertion until the master reports progress (act high or a next pulse); "byte done" SHALL be detected on the rising edge of next.
REQ-016 INIT_REG SHALL assert en with write=1 and wdata=8'h6B; on byte done it SHALL go to INIT_DATA.
REQ-017 INIT_DATA SHALL drive wdata=8'h01 with en held; on byte done it SHALL deassert en and go to INIT_STOP.
REQ-018 INIT_STOP SHALL wait for act low, then go to WAIT and reload the period counter.
REQ-019 The period counter SHALL count SYSTEM_CLOCK/SAMPLE_RATE-1 down to 0, using integer division.
REQ-020 In WAIT, a counter value of 0 with act low SHALL go to RD_REG and reload the counter; the counter SHALL run in all states after init, and an expiry while not in WAIT SHALL be held pending, with at most one pending expiry.
REQ-021 RD_REG SHALL assert en with write=1 and wdata=8'h3B; on byte done it SHALL go to RD_RESTART.
REQ-022 RD_RESTART SHALL drive write=0 with en held, which makes the master issue a repeated start; it SHALL then go to RD_DATA.
REQ-023 RD_DATA SHALL capture rdata on each byte done into a 14-byte buffer at index 0..13, using a 4-bit byte counter.
REQ-024 In RD_DATA, en SHALL stay high through byte index 12 and be deasserted in the cycle after byte done of index 12, so that byte 13 is the last byte (NACK + stop).
REQ-025 RD_STOP SHALL wait for act low, then in one cycle load the outputs big-endian: accel_x={b0,b1}, accel_y={b2,b3}, accel_z={b4,b5}, temp={b6,b7}, gyro_x={b8,b9}, gyro_y={b10,b11}, gyro_z={b12,b13}; assert sample_valid for one cycle; and go to WAIT.
REQ-026 An err pulse in any non-WAIT state SHALL go to ABORT.
REQ-027 Watchdog: the watchdog counter SHALL reset on each byte done and on each state entry; reaching WDOG_CYCLES SHALL go to ABORT.
REQ-028 ABORT SHALL deassert en, increment err_count (saturating at 255), wait for act low, and then go to INIT_REG if the aborted transaction was in an INIT state, else to WAIT; ABORT SHALL produce no sample_valid and leave the output words unchanged.
REQ-029 If err and byte done coincide, err SHALL take priority.
REQ-030 After any abort, the byte counter and buffer SHALL be discarded; the next read SHALL restart at index 0.

Reset
REQ-031 rst SHALL take priority over all other inputs, is synchronous, and SHALL be valid mid-transaction.
REQ-032 On reset: state=INIT_REG with en=0 for one cycle; en=0, write=0, wdata=0, sample_valid=0, busy=0, err_count=0, all sample words=0, counters=0, pending=0.
REQ-033 Reset during an active bus transaction SHALL drop en immediately; the master completing its current byte is not this block's concern.

Verification
REQ-034 Scenario: release rst with an ACKing slave model -> write frame of 0x6B then 0x01 followed by stop; busy falls; the first RD_REG occurs SYSTEM_CLOCK/SAMPLE_RATE cycles later.
REQ-035 Scenario: the slave returns bytes 0x01..0x0E -> accel_x=16'h0102 and gyro_z=16'h0D0E, with a single sample_valid pulse after act low.
REQ-036 Scenario: the slave NACKs the address during a read -> err_count=1, no sample_valid, previous words held, and the next read starts one period later.
REQ-037 Scenario: NACK during INIT_DATA -> err_count=1 and the init write is retried from 0x6B.
REQ-038 Scenario: the master stalls next for WDOG_CYCLES -> ABORT, en=0, err_count increments; 300 forced errors -> err_count=255.
REQ-039 Scenario: assert rst at byte index 7 of a read -> en=0 the next cycle, all outputs are at reset values, and init restarts.
